// File: rtl/lut_udp_pkg.sv
// Shared types and constants for the LUT-based user-defined-primitive unit.
package lut_udp_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_TABLE = 8'hD5;

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader: MSB-first shift into a shadow register with a bit counter.
module lut_cfg_loader #(
    parameter int W = 8,
    parameter logic [W-1:0] RESET_TABLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         cfg_bit,
    output logic [W-1:0] shadow,
    output logic         last_bit
);

    localparam int CNT_W = $clog2(W + 1);

    logic [CNT_W-1:0] count_reg;
    logic [W-1:0]     shadow_reg;

    // Shifting stops once the table is full so extra bits cannot corrupt it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            shadow_reg <= RESET_TABLE;
        end else if (clear) begin
            count_reg  <= '0;
        end else if (shift_en && !last_bit) begin
            shadow_reg <= {shadow_reg[W-2:0], cfg_bit};
            count_reg  <= count_reg + 1'b1;
        end
    end

    assign last_bit = (count_reg == CNT_W'(W));
    assign shadow   = shadow_reg;

endmodule

// File: rtl/lut_udp_unit.sv
// Table-lookup primitive with a one-deep output register and in-system serial table reload.
module lut_udp_unit
    import lut_udp_pkg::*;
#(
    parameter int N_IN = 3,
    parameter logic [2**N_IN-1:0] RESET_TABLE = DEFAULT_TABLE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_sel,
    input  logic            in_gate,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_e,
    output logic            out_f,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_done,
    output logic            busy
);

    localparam int W = 2**N_IN;

    state_t         state_reg, state_next;
    logic [W-1:0]   table_reg;
    logic           out_valid_reg, out_e_reg, out_f_reg, cfg_done_reg;
    logic [W-1:0]   shadow;
    logic           last_bit;
    logic           load_entry, shift_en, commit, out_free;

    assign out_free = !out_valid_reg || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_RUN;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                in_ready = out_free && !cfg_start;
                if (cfg_start) state_next = out_free ? ST_LOAD : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (last_bit) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign load_entry = (state_next == ST_LOAD) && (state_reg != ST_LOAD);
    assign shift_en   = (state_reg == ST_LOAD) && cfg_valid;
    assign commit     = (state_reg == ST_LOAD) && last_bit;

    lut_cfg_loader #(
        .W           (W),
        .RESET_TABLE (RESET_TABLE)
    ) u_loader (
        .clk      (clk),
        .rst      (rst),
        .clear    (load_entry),
        .shift_en (shift_en),
        .cfg_bit  (cfg_bit),
        .shadow   (shadow),
        .last_bit (last_bit)
    );

    // The active table only changes on the commit edge, never mid-load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_reg    <= RESET_TABLE;
            cfg_done_reg <= 1'b0;
        end else begin
            cfg_done_reg <= commit;
            if (commit) table_reg <= shadow;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_e_reg     <= 1'b0;
            out_f_reg     <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid_reg <= 1'b1;
            out_e_reg     <= table_reg[in_sel];
            out_f_reg     <= table_reg[in_sel] & in_gate;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_e     = out_e_reg;
    assign out_f     = out_f_reg;
    assign cfg_done  = cfg_done_reg;
    assign busy      = (state_reg != ST_RUN);

endmodule

// File: tb/tb_lut_udp_unit.sv
// Directed and scoreboarded checks for lut_udp_unit with the default 3-input table.
module tb_lut_udp_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_sel = 3'd0;
    logic       in_gate = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_e, out_f;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       cfg_done;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lut_udp_unit #(.N_IN(3), .RESET_TABLE(8'hD5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_gate   (in_gate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_e     (out_e),
        .out_f     (out_f),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_done  (cfg_done),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted request, result checked on the following cycle.
    task automatic eval(input string tag, input logic [2:0] sel, input logic gate,
                        input logic exp_e, input logic exp_f);
        @(negedge clk);
        in_valid = 1'b1; in_sel = sel; in_gate = gate; out_ready = 1'b1;
        #1 check({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_e"}, out_e, exp_e);
        check({tag, "_f"}, out_f, exp_f);
        $display("eval %s sel=%b gate=%b -> e=%b f=%b", tag, sel, gate, out_e, out_f);
    endtask

    task automatic start_load(input string tag);
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check({tag, "_busy"}, busy, 1);
    endtask

    // Shifts MSB first; optional idle cycles carry a stray cfg_start that must be ignored.
    task automatic shift_table(input string tag, input logic [7:0] value, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps && (i % 3 == 0)) begin
                cfg_valid = 1'b0; cfg_start = 1'b1;
                @(negedge clk);
                cfg_start = 1'b0;
            end
            cfg_valid = 1'b1; cfg_bit = value[i];
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check({tag, "_done_early"}, cfg_done, 0);
        check({tag, "_busy_last"}, busy, 1);
        @(negedge clk);
        check({tag, "_done"}, cfg_done, 1);
        check({tag, "_busy_run"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, cfg_done, 0);
        $display("load %s table=%h", tag, value);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tbl;
        logic [1:0] q[$];
        logic [1:0] exp_ef;
        logic       model_ov;
        logic       acc;

        // Reset state
        #2;
        check("rst_ov", out_valid, 0);
        check("rst_e", out_e, 0);
        check("rst_f", out_f, 0);
        check("rst_done", cfg_done, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Default table 8'hD5
        eval("d5_s1", 3'b001, 1'b1, 1'b0, 1'b0);
        eval("d5_s7", 3'b111, 1'b0, 1'b1, 1'b0);
        eval("d5_s6", 3'b110, 1'b1, 1'b1, 1'b1);

        // XOR3 load
        start_load("x3");
        shift_table("x3", 8'h96, 1'b0);
        eval("x3_s3", 3'b011, 1'b1, 1'b0, 1'b0);
        eval("x3_s7", 3'b111, 1'b1, 1'b1, 1'b1);

        // Load with cfg_valid gaps and ignored cfg_start pulses
        start_load("gap");
        shift_table("gap", 8'h3C, 1'b1);
        eval("gap_s6", 3'b110, 1'b1, 1'b0, 1'b0);
        eval("gap_s5", 3'b101, 1'b1, 1'b1, 1'b1);
        eval("gap_s2", 3'b010, 1'b0, 1'b1, 1'b0);

        // Drain before loading
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'b101; in_gate = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check("dr_ov", out_valid, 1);
        check("dr_e", out_e, 1);
        cfg_start = 1'b1;
        #1 check("dr_rdy_start", in_ready, 0);
        @(negedge clk);
        cfg_start = 1'b0;
        check("dr_busy", busy, 1);
        check("dr_rdy", in_ready, 0);
        @(negedge clk);
        check("dr_hold_ov", out_valid, 1);
        check("dr_hold_e", out_e, 1);
        check("dr_hold_f", out_f, 1);
        out_ready = 1'b1;
        #1 check("dr_rdy_or", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b0;
        check("dr_ov_gone", out_valid, 0);
        check("dr_busy_load", busy, 1);
        shift_table("maj", 8'hE8, 1'b0);
        eval("maj_s3", 3'b011, 1'b1, 1'b1, 1'b1);
        eval("maj_s4", 3'b100, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a load
        start_load("abort");
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b0;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("ab_busy", busy, 0);
        check("ab_ov", out_valid, 0);
        check("ab_done", cfg_done, 0);
        @(negedge clk);
        rst = 1'b0;
        eval("ab_s1", 3'b001, 1'b1, 1'b0, 1'b0);
        eval("ab_s7", 3'b111, 1'b1, 1'b1, 1'b1);
        eval("ab_s0", 3'b000, 1'b1, 1'b1, 1'b1);
        eval("ab_s4", 3'b100, 1'b1, 1'b1, 1'b1);

        // Random stream against a scoreboard
        tbl = 8'hD5;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        model_ov = 1'b0;
        for (int c = 0; c < 240; c++) begin
            in_valid  = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_sel    = 3'($urandom_range(0, 7));
            in_gate   = 1'($urandom_range(0, 1));
            out_ready = (c < 200) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            check("rnd_ov", out_valid, model_ov);
            check("rnd_rdy", in_ready, !model_ov || out_ready);
            if (model_ov && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_q_empty", 0, 1);
                end else begin
                    exp_ef = q.pop_front();
                    check("rnd_e", out_e, exp_ef[1]);
                    check("rnd_f", out_f, exp_ef[0]);
                    $display("rnd cycle %0d pop e=%b f=%b", c, out_e, out_f);
                end
            end
            acc = in_valid && (!model_ov || out_ready);
            if (acc) q.push_back({tbl[in_sel], tbl[in_sel] & in_gate});
            model_ov = acc ? 1'b1 : ((model_ov && out_ready) ? 1'b0 : model_ov);
            @(negedge clk);
        end
        check("rnd_q_left", q.size(), 0);
        check("rnd_ov_end", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_udp_unit.md
LUT_UDP_UNIT -- requirements
Module: lut_udp_unit

Interface
REQ-001 Parameter N_IN, default 3, SHALL set the number of select inputs (legal 2..6).
REQ-002 Parameter RESET_TABLE, default 8'hD5, width 2**N_IN, SHALL be the truth table loaded at reset: bit i is the output for select value i.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-005 Port in_valid, input, 1 bit, SHALL mark a valid evaluation request.
REQ-006 Port in_ready, output, 1 bit, SHALL mark that a request is accepted this cycle.
REQ-007 Port in_sel, input, N_IN bits, SHALL be the select vector; MSB is input A, LSB is the last input.
REQ-008 Port in_gate, input, 1 bit, SHALL be the gating operand D for out_f.
REQ-009 Port out_valid, output, 1 bit, SHALL mark that out_e and out_f hold a valid result.
REQ-010 Port out_ready, input, 1 bit, SHALL mark downstream acceptance.
REQ-011 Port out_e, output, 1 bit, SHALL be the table lookup result.
REQ-012 Port out_f, output, 1 bit, SHALL be out_e AND the captured in_gate.
REQ-013 Port cfg_start, input, 1 bit, SHALL request a truth-table reload (single-cycle pulse).
REQ-014 Port cfg_valid, input, 1 bit, SHALL qualify cfg_bit during loading.
REQ-015 Port cfg_bit, input, 1 bit, SHALL be the serial table data, MSB (entry 2**N_IN-1) first.
REQ-016 Port cfg_done, output, 1 bit, SHALL pulse high for one cycle when a new table is committed.
REQ-017 Port busy, output, 1 bit, SHALL be high whenever the FSM state is not RUN.

Function
REQ-018 The FSM SHALL have the states RUN, DRAIN and LOAD.
REQ-019 In RUN, in_ready SHALL equal (!out_valid || out_ready) and be 0 in every other state, and 0 in any cycle in which cfg_start is high.
REQ-020 An accepted request SHALL produce out_e = table[in_sel] and out_f = table[in_sel] & in_gate on the next cycle with out_valid=1; latency is exactly 1 cycle.
REQ-021 A held result (out_valid=1, out_ready=0) SHALL keep out_e and out_f stable until out_ready=1.
REQ-022 Simultaneous accept and output handshake SHALL give back-to-back throughput of 1 result per cycle.
REQ-023 cfg_start in RUN SHALL go to LOAD if out_valid=0 or out_ready=1 in that cycle, otherwise to DRAIN.
REQ-024 DRAIN SHALL go to LOAD in the cycle the pending result is accepted.
REQ-025 LOAD SHALL shift cfg_bit into a shadow register on each cycle with cfg_valid=1, and SHALL hold in cycles with cfg_valid=0.
REQ-026 After 2**N_IN valid bits, the shadow register SHALL be copied to the active table on the next edge, cfg_done SHALL pulse, and the state SHALL return to RUN.
REQ-027 The active table SHALL never change during LOAD, so no partial table is ever visible.
REQ-028 cfg_start in DRAIN or LOAD SHALL be ignored.
REQ-029 The bit counter SHALL be ceil(log2(2**N_IN+1)) bits wide and SHALL clear on entry to LOAD.

Reset
REQ-030 rst SHALL force: state RUN, active and shadow table RESET_TABLE, counter 0, out_valid 0, out_e 0, out_f 0, cfg_done 0.
REQ-031 rst asserted during DRAIN or LOAD SHALL discard the partial load and restore RESET_TABLE.

Structure
REQ-032 Package lut_udp_pkg SHALL hold the state enum and the default table constant 8'hD5.
REQ-033 Serial shifting and counting SHALL live in sub-module lut_cfg_loader (shadow register, counter, last-bit flag).

Verification
REQ-034 Default table: in_sel=3'b001, gate=1 -> out_e=0, out_f=0; in_sel=3'b111, gate=0 -> out_e=1, out_f=0; in_sel=3'b110, gate=1 -> out_e=1, out_f=1.
REQ-035 Load 8'h96 (XOR3) -> cfg_done after the 8th bit; then in_sel=3'b011 -> out_e=0, in_sel=3'b111 -> out_e=1.
REQ-036 Hold out_ready=0 with a result pending, pulse cfg_start -> DRAIN, busy=1, in_ready=0; release out_ready -> LOAD next cycle.
REQ-037 Gaps in cfg_valid during LOAD -> commit still after exactly 8 valid bits, table correct.
REQ-038 Assert rst after 4 of 8 bits -> table reads 8'hD5, state RUN, out_valid=0.
REQ-039 Random stream with out_ready toggling -> no result lost or duplicated, and the order is preserved against the reference model.
